// File: rtl/pipeline_ctrl_pkg.sv
// Shared pipeline types and stall thermometer constants for the stall/flush controller.
package pipeline_ctrl_pkg;

  typedef logic        Bit_t;
  typedef logic [5:0]  Stall_t;
  typedef logic [31:0] Inst_addr_t;

  localparam Bit_t       ENABLE        = 1'b1;
  localparam Bit_t       DISABLE       = 1'b0;
  localparam Inst_addr_t PC_RESET_ADDR = 32'hBFC0_0000;

  // Bit order: 0 pc, 1 if, 2 id, 3 ex, 4 mem, 5 wb.
  localparam Stall_t STALL_NONE     = 6'b000000;
  localparam Stall_t STALL_FROM_IF  = 6'b000011;
  localparam Stall_t STALL_FROM_ID  = 6'b000111;
  localparam Stall_t STALL_FROM_EX  = 6'b001111;
  localparam Stall_t STALL_FROM_MEM = 6'b011111;
  localparam Stall_t STALL_ALL      = 6'b111111;

  function automatic Bit_t is_stalled(input Stall_t s);
    return (s != STALL_NONE) ? ENABLE : DISABLE;
  endfunction

endpackage

// File: rtl/pipeline_ctrl_if.sv
// Stall request / exception / redirect bundle between the pipeline stages and pipeline_ctrl.
interface pipeline_ctrl_if #(
  parameter int CNT_WIDTH = 32
);
  import pipeline_ctrl_pkg::*;

  Bit_t                 stallreq_if;
  Bit_t                 stallreq_id;
  Bit_t                 stallreq_ex;
  Bit_t                 stallreq_mem;
  Bit_t                 excp_valid;
  Inst_addr_t           excp_target;
  Bit_t                 if_busy;
  Stall_t               stall;
  Bit_t                 flush;
  Inst_addr_t           new_pc;
  logic [CNT_WIDTH-1:0] stall_cycles;

  modport master (
    output stallreq_if, stallreq_id, stallreq_ex, stallreq_mem,
    output excp_valid, excp_target, if_busy,
    input  stall, flush, new_pc, stall_cycles
  );

  modport slave (
    input  stallreq_if, stallreq_id, stallreq_ex, stallreq_mem,
    input  excp_valid, excp_target, if_busy,
    output stall, flush, new_pc, stall_cycles
  );

endinterface

// File: rtl/pipeline_ctrl_stall_encoder.sv
// Combinational priority encoder: highest requesting stage picks the stall thermometer.
module stall_encoder
  import pipeline_ctrl_pkg::*;
(
  input  Bit_t   req_if,
  input  Bit_t   req_id,
  input  Bit_t   req_ex,
  input  Bit_t   req_mem,
  output Stall_t stall
);

  always_comb begin
    stall = STALL_NONE;
    if (req_mem)     stall = STALL_FROM_MEM;
    else if (req_ex) stall = STALL_FROM_EX;
    else if (req_id) stall = STALL_FROM_ID;
    else if (req_if) stall = STALL_FROM_IF;
  end

endmodule

// File: rtl/pipeline_ctrl.sv
// Stall/flush controller: zero-latency stall vector, one-cycle flush + redirect, parks
// exceptions until IF's bus transaction completes; exports a saturating stall-cycle counter.
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int CNT_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  pipeline_ctrl_if.slave        bus
);

  typedef enum logic {
    RUN,
    WAIT_IF
  } state_t;

  state_t               state_q;
  state_t               state_d;
  Inst_addr_t           pend_pc_q;
  logic [CNT_WIDTH-1:0] cnt_q;
  Stall_t               req_stall;
  Stall_t               stall;
  Bit_t                 flush;
  Inst_addr_t           new_pc;
  Bit_t                 park;

  stall_encoder u_enc (
    .req_if  (bus.stallreq_if),
    .req_id  (bus.stallreq_id),
    .req_ex  (bus.stallreq_ex),
    .req_mem (bus.stallreq_mem),
    .stall   (req_stall)
  );

  always_comb begin
    state_d = state_q;
    stall   = STALL_NONE;
    flush   = DISABLE;
    new_pc  = PC_RESET_ADDR;
    park    = DISABLE;
    if (!rst) begin
      unique case (state_q)
        RUN: begin
          if (bus.excp_valid) begin
            if (bus.if_busy) begin
              // IF cannot abandon its fetch: freeze everything and redirect later.
              stall   = STALL_ALL;
              park    = ENABLE;
              state_d = WAIT_IF;
            end else begin
              flush  = ENABLE;
              new_pc = bus.excp_target;
            end
          end else begin
            stall = req_stall;
          end
        end
        WAIT_IF: begin
          if (bus.if_busy) begin
            stall = STALL_ALL;
          end else begin
            flush   = ENABLE;
            new_pc  = pend_pc_q;
            state_d = RUN;
          end
        end
        default: state_d = RUN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= RUN;
      pend_pc_q <= PC_RESET_ADDR;
      cnt_q     <= '0;
    end else begin
      state_q <= state_d;
      if (park) pend_pc_q <= bus.excp_target;
      if (is_stalled(stall) && (cnt_q != {CNT_WIDTH{1'b1}})) cnt_q <= cnt_q + 1'b1;
    end
  end

  assign bus.stall        = stall;
  assign bus.flush        = flush;
  assign bus.new_pc       = new_pc;
  assign bus.stall_cycles = cnt_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl: two instances (32-bit and 4-bit counters) checked every cycle against a behavioural model.
module tb_pipeline_ctrl;
  import pipeline_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst;
  logic r_if, r_id, r_ex, r_mem, r_excp, r_busy;
  logic [31:0] r_tgt;

  always #5 clk = ~clk;

  pipeline_ctrl_if #(.CNT_WIDTH(32)) b32 ();
  pipeline_ctrl_if #(.CNT_WIDTH(4))  b4 ();

  assign b32.stallreq_if  = r_if;   assign b4.stallreq_if  = r_if;
  assign b32.stallreq_id  = r_id;   assign b4.stallreq_id  = r_id;
  assign b32.stallreq_ex  = r_ex;   assign b4.stallreq_ex  = r_ex;
  assign b32.stallreq_mem = r_mem;  assign b4.stallreq_mem = r_mem;
  assign b32.excp_valid   = r_excp; assign b4.excp_valid   = r_excp;
  assign b32.excp_target  = r_tgt;  assign b4.excp_target  = r_tgt;
  assign b32.if_busy      = r_busy; assign b4.if_busy      = r_busy;

  pipeline_ctrl #(.CNT_WIDTH(32)) dut32 (.clk(clk), .rst(rst), .bus(b32.slave));
  pipeline_ctrl #(.CNT_WIDTH(4))  dut4  (.clk(clk), .rst(rst), .bus(b4.slave));

  int checks = 0;
  int errors = 0;

  // Behavioural model: "parked" flag, remembered redirect, and two counters.
  bit          m_parked;
  logic [31:0] m_pend;
  longint      m_cnt32, m_cnt4;
  bit          m_cnt_known;
  logic [5:0]  e_stall;
  logic        e_flush;
  logic [31:0] e_pc;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%h want=%h t=%0t", name, got, want, $time);
    end
  endtask

  function automatic logic [5:0] therm();
    int h;
    h = -1;
    if (r_if)  h = 1;
    if (r_id)  h = 2;
    if (r_ex)  h = 3;
    if (r_mem) h = 4;
    return (h < 0) ? 6'd0 : 6'((1 << (h + 1)) - 1);
  endfunction

  task automatic compute_expect();
    e_stall = 6'd0;
    e_flush = 1'b0;
    e_pc    = 32'hBFC0_0000;
    if (rst) begin
    end else if (m_parked || r_excp) begin
      if (r_busy) e_stall = 6'h3F;
      else begin
        e_flush = 1'b1;
        e_pc    = m_parked ? m_pend : r_tgt;
      end
    end else begin
      e_stall = therm();
    end
  endtask

  task automatic sample(input string tag);
    @(negedge clk);
    compute_expect();
    chk({tag, "_stall"},  {26'd0, b32.stall}, {26'd0, e_stall});
    chk({tag, "_flush"},  {31'd0, b32.flush}, {31'd0, e_flush});
    chk({tag, "_new_pc"}, b32.new_pc, e_pc);
    chk({tag, "_stall4"}, {26'd0, b4.stall}, {26'd0, e_stall});
    if (m_cnt_known) begin
      chk({tag, "_cnt32"}, b32.stall_cycles, 32'(m_cnt32));
      chk({tag, "_cnt4"},  {28'd0, b4.stall_cycles}, 32'(m_cnt4));
    end
  endtask

  task automatic advance();
    @(posedge clk);
    if (rst) begin
      m_parked = 0; m_pend = 32'hBFC0_0000; m_cnt32 = 0; m_cnt4 = 0; m_cnt_known = 1;
    end else begin
      if (e_stall != 0) begin
        if (m_cnt32 < 64'hFFFF_FFFF) m_cnt32++;
        if (m_cnt4 < 15) m_cnt4++;
      end
      if (!m_parked && r_excp && r_busy) begin
        m_parked = 1; m_pend = r_tgt;
      end else if (m_parked && !r_busy) begin
        m_parked = 0;
      end
    end
    #1;
  endtask

  task automatic idle();
    r_if = 0; r_id = 0; r_ex = 0; r_mem = 0; r_excp = 0; r_busy = 0; r_tgt = 32'h0;
  endtask

  task automatic cyc(input string tag);
    sample(tag);
    advance();
  endtask

  logic [31:0] cnt_before;

  initial begin
    m_cnt_known = 0; m_parked = 0; m_pend = 32'hBFC0_0000; m_cnt32 = 0; m_cnt4 = 0;
    idle();
    rst = 1;
    r_id = 1; r_excp = 1; r_tgt = 32'hDEAD_BEEF;
    sample("rst0");
    chk("rst0_stall_lit", {26'd0, b32.stall}, 32'd0);
    chk("rst0_pc_lit", b32.new_pc, 32'hBFC0_0000);
    advance();
    idle();
    cyc("rst1");
    rst = 0;

    // load-use hazard for three cycles
    r_id = 1;
    for (int i = 0; i < 3; i++) begin
      sample("id3");
      chk("id3_stall_lit", {26'd0, b32.stall}, 32'h07);
      advance();
    end
    idle();
    sample("id3_after");
    chk("id3_cnt_lit", b32.stall_cycles, 32'd3);
    advance();

    r_if = 1; r_ex = 1;
    sample("if_ex");
    chk("if_ex_stall_lit", {26'd0, b32.stall}, 32'h0F);
    advance();

    // every request combination
    for (int v = 0; v < 16; v++) begin
      r_if = v[0]; r_id = v[1]; r_ex = v[2]; r_mem = v[3];
      cyc("combo");
    end
    idle();

    // immediate exception beats a mem stall
    cnt_before = b32.stall_cycles;
    r_mem = 1; r_excp = 1; r_tgt = 32'hBFC0_0380;
    sample("excp_now");
    chk("excp_now_flush_lit", {31'd0, b32.flush}, 32'd1);
    chk("excp_now_pc_lit", b32.new_pc, 32'hBFC0_0380);
    chk("excp_now_stall_lit", {26'd0, b32.stall}, 32'd0);
    advance();
    idle();
    sample("excp_now_after");
    chk("excp_now_cnt_lit", b32.stall_cycles, cnt_before);
    advance();

    // parked exception, IF busy for 4 cycles, second exception ignored
    cnt_before = b32.stall_cycles;
    r_excp = 1; r_busy = 1; r_tgt = 32'h8000_0180;
    sample("park0");
    chk("park0_stall_lit", {26'd0, b32.stall}, 32'h3F);
    advance();
    r_excp = 0;
    cyc("park1");
    r_excp = 1; r_tgt = 32'h1234_5678; r_id = 1;
    cyc("park2");
    r_excp = 0; r_id = 0;
    cyc("park3");
    r_busy = 0; r_tgt = 32'h0;
    sample("park_flush");
    chk("park_flush_lit", {31'd0, b32.flush}, 32'd1);
    chk("park_pc_lit", b32.new_pc, 32'h8000_0180);
    advance();
    sample("park_run");
    chk("park_run_flush_lit", {31'd0, b32.flush}, 32'd0);
    chk("park_cnt_lit", b32.stall_cycles, cnt_before + 32'd4);
    advance();

    // minimal park: one frozen cycle then flush
    r_excp = 1; r_busy = 1; r_tgt = 32'h8000_0200;
    cyc("minpark0");
    idle();
    sample("minpark1");
    chk("minpark_pc_lit", b32.new_pc, 32'h8000_0200);
    advance();
    cyc("minpark2");

    // reset during the wait drops the redirect
    r_excp = 1; r_busy = 1; r_tgt = 32'h8000_0300;
    cyc("rstw0");
    r_excp = 0;
    cyc("rstw1");
    rst = 1;
    cyc("rstw2");
    rst = 0;
    sample("rstw3");
    chk("rstw3_stall_lit", {26'd0, b32.stall}, 32'd0);
    chk("rstw3_cnt_lit", b32.stall_cycles, 32'd0);
    advance();
    r_busy = 0;
    sample("rstw4");
    chk("rstw4_noflush_lit", {31'd0, b32.flush}, 32'd0);
    advance();

    // counter saturation on the narrow instance
    r_ex = 1;
    for (int i = 0; i < 20; i++) cyc("sat");
    idle();
    sample("sat_end");
    chk("sat4_lit", {28'd0, b4.stall_cycles}, 32'd15);
    chk("sat32_lit", b32.stall_cycles, 32'd20);
    advance();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
